lfsr_32_checker: RTL and testbench

LFSR_32_CHECKER -- requirements
Module: lfsr_32_checker

---
 rtl/lfsr_pkg.sv | 28 ++
 rtl/lfsr_popcount32.sv | 15 +
 rtl/lfsr_32_checker.sv | 141 ++++++++++++++
 tb/tb_lfsr_32_checker.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 32-bit LFSR generator/checker pair:
// tap positions, reset seed, checker state encoding and the step function.
package lfsr_pkg;

    localparam int unsigned LfsrW = 32;

    // x^32 + x^22 + x^2 + x + 1
    localparam int unsigned TapA = 31;
    localparam int unsigned TapB = 21;
    localparam int unsigned TapC = 1;
    localparam int unsigned TapD = 0;

    localparam logic [LfsrW-1:0] LfsrSeed = 32'h1234_5678;

    typedef enum logic [1:0] {
        StSearch = 2'd0,
        StVerify = 2'd1,
        StLocked = 2'd2
    } chk_state_e;

    // One generator step: shift left, feedback into bit 0.
    function automatic logic [LfsrW-1:0] lfsr_next(input logic [LfsrW-1:0] s);
        logic fb;
        fb = s[TapA] ^ s[TapB] ^ s[TapC] ^ s[TapD];
        return {s[LfsrW-2:0], fb};
    endfunction

endpackage

// File: rtl/lfsr_popcount32.sv
// 32-bit combinational population count; used for bit-error weighting.
module lfsr_popcount32 (
    input  logic [31:0] i_data,
    output logic [5:0]  o_count
);

    // Sum the set bits of the input word.
    always_comb begin
        o_count = '0;
        for (int i = 0; i < 32; i++) begin
            o_count = o_count + {5'd0, i_data[i]};
        end
    end

endmodule

// File: rtl/lfsr_32_checker.sv
// Receive-side checker for a 32-bit LFSR stream. Acquires lock from the
// incoming words, then flywheels the expected sequence and counts errors.
// Build option: define LFSR_CHK_BITERR_EN to weight each mismatched word by
// the number of differing bits instead of counting one per word.
module lfsr_32_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned LOSS_CNT = 3,
    parameter int unsigned ERR_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    input  logic             clear_err,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [3:0]  LockCnt = LOCK_CNT[3:0];
    localparam logic [3:0]  LossCnt = LOSS_CNT[3:0];
    // Headroom so base + 32 can never wrap before the saturation test.
    localparam int unsigned SumW    = ERR_W + 6;

    chk_state_e       r_state;
    logic [31:0]      r_expected;
    logic [3:0]       r_match_cnt;
    logic [3:0]       r_miss_cnt;
    logic             r_locked;
    logic             r_err_pulse;
    logic [ERR_W-1:0] r_err_count;

    logic [31:0]      w_next_in;
    logic [31:0]      w_next_exp;
    logic             w_match;
    logic             w_err;
    logic [5:0]       w_inc;
    logic [ERR_W-1:0] w_err_base;
    logic [ERR_W-1:0] w_err_next;
    logic [SumW-1:0]  w_sum;

    assign w_next_in  = lfsr_next(in_data);
    assign w_next_exp = lfsr_next(r_expected);
    assign w_match    = (in_data == r_expected);
    // Errors only exist once the flywheel is running.
    assign w_err      = in_valid && (r_state == StLocked) && !w_match;

`ifdef LFSR_CHK_BITERR_EN
    logic [31:0] w_diff;
    assign w_diff = in_data ^ r_expected;

    lfsr_popcount32 u_popcount (
        .i_data  (w_diff),
        .o_count (w_inc)
    );
`else
    assign w_inc = 6'd1;
`endif

    // Next error count: clear first, then add this cycle's increment, saturating.
    always_comb begin
        w_err_base = clear_err ? '0 : r_err_count;
        w_sum      = {6'd0, w_err_base} + {{(SumW-6){1'b0}}, w_inc};
        w_err_next = w_err_base;
        if (w_err) begin
            if (|w_sum[SumW-1:ERR_W]) begin
                w_err_next = '1;
            end else begin
                w_err_next = w_sum[ERR_W-1:0];
            end
        end
    end

    // Acquisition FSM with registered lock/error outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= StSearch;
            r_expected  <= LfsrSeed;
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_err_pulse <= w_err;
            r_err_count <= w_err_next;
            if (in_valid) begin
                unique case (r_state)
                    StSearch: begin
                        // All-zero words are the LFSR lockup state; never seed from them.
                        if (in_data != '0) begin
                            r_expected  <= w_next_in;
                            r_match_cnt <= '0;
                            r_state     <= StVerify;
                        end
                    end
                    StVerify: begin
                        if (w_match) begin
                            r_expected  <= w_next_in;
                            r_match_cnt <= r_match_cnt + 4'd1;
                            if (r_match_cnt + 4'd1 == LockCnt) begin
                                r_state    <= StLocked;
                                r_locked   <= 1'b1;
                                r_miss_cnt <= '0;
                            end
                        end else if (in_data == '0) begin
                            r_match_cnt <= '0;
                            r_state     <= StSearch;
                        end else begin
                            r_expected  <= w_next_in;
                            r_match_cnt <= '0;
                        end
                    end
                    StLocked: begin
                        // Flywheel: the input never reseeds once locked.
                        r_expected <= w_next_exp;
                        if (w_match) begin
                            r_miss_cnt <= '0;
                        end else begin
                            r_miss_cnt <= r_miss_cnt + 4'd1;
                            if (r_miss_cnt + 4'd1 == LossCnt) begin
                                r_state  <= StSearch;
                                r_locked <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        r_state <= StSearch;
                    end
                endcase
            end
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_lfsr_32_checker.sv
// Directed bench for lfsr_32_checker. ERR_W is narrowed to 4 so saturation
// (2^W-2 -> 2^W-1) is reachable in a few dozen words.
module tb_lfsr_32_checker;

    localparam int unsigned ErrW = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            in_valid = 1'b0;
    logic [31:0]     in_data = '0;
    logic            clear_err = 1'b0;
    logic            locked;
    logic            err_pulse;
    logic [ErrW-1:0] err_count;

    int unsigned n_vec = 0;
    int unsigned n_miss = 0;
    logic [31:0] s;

    always #5 clk = ~clk;

    lfsr_32_checker #(
        .LOCK_CNT (4),
        .LOSS_CNT (3),
        .ERR_W    (ErrW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .clear_err (clear_err),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    function automatic logic [31:0] gen_next(input logic [31:0] v);
        return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic clr);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        clear_err = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic good_word();
        step(1'b1, s, 1'b0);
        s = gen_next(s);
    endtask

    task automatic bad_word(input logic clr);
        step(1'b1, s ^ 32'h1, clr);
        s = gen_next(s);
    endtask

    task automatic acquire(input logic [31:0] seed);
        s = seed;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, s, 1'b0);
            s = gen_next(s);
            if (i == 3) check_eq("acq_early", 32'(locked), 32'd0);
        end
        check_eq("acq_lock", 32'(locked), 32'd1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_locked", 32'(locked), 32'd0);
        check_eq("rst_pulse", 32'(err_pulse), 32'd0);
        check_eq("rst_errcnt", 32'(err_count), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        repeat (10) step(1'b1, 32'h0, 1'b0);
        check_eq("zero_search", 32'(locked), 32'd0);

        acquire(32'h1234_5678);
        check_eq("acq_errcnt", 32'(err_count), 32'd0);

        repeat (3) step(1'b0, 32'hDEAD_BEEF, 1'b0);
        check_eq("gap_locked", 32'(locked), 32'd1);
        check_eq("gap_pulse", 32'(err_pulse), 32'd0);
        check_eq("gap_errcnt", 32'(err_count), 32'd0);

        bad_word(1'b0);
        check_eq("bit0_pulse", 32'(err_pulse), 32'd1);
        check_eq("bit0_errcnt", 32'(err_count), 32'd1);
        check_eq("bit0_locked", 32'(locked), 32'd1);
        good_word();
        check_eq("pulse_once", 32'(err_pulse), 32'd0);
        check_eq("flywheel_errcnt", 32'(err_count), 32'd1);

        bad_word(1'b0);
        bad_word(1'b0);
        good_word();
        bad_word(1'b0);
        bad_word(1'b0);
        check_eq("miss_reset_locked", 32'(locked), 32'd1);
        check_eq("miss_reset_errcnt", 32'(err_count), 32'd5);
        good_word();

        step(1'b0, 32'h0, 1'b1);
        check_eq("clr_errcnt", 32'(err_count), 32'd0);
        check_eq("clr_locked", 32'(locked), 32'd1);

        bad_word(1'b0);
        bad_word(1'b0);
        check_eq("loss_hold", 32'(locked), 32'd1);
        bad_word(1'b0);
        check_eq("loss_locked", 32'(locked), 32'd0);
        check_eq("loss_errcnt", 32'(err_count), 32'd3);
        check_eq("loss_pulse", 32'(err_pulse), 32'd1);

        step(1'b1, 32'hCAFE_F00D, 1'b0);
        step(1'b1, 32'h1111_1111, 1'b0);
        check_eq("verify_no_pulse", 32'(err_pulse), 32'd0);
        check_eq("verify_no_count", 32'(err_count), 32'd3);

        // A zero in VERIFY must fall back to SEARCH, not seed a zero stream.
        repeat (10) step(1'b1, 32'h0, 1'b0);
        check_eq("verify_zero", 32'(locked), 32'd0);

        s = 32'hA5A5_0001;
        repeat (3) good_word();
        step(1'b1, 32'h0F0F_0F0F, 1'b0);
        s = gen_next(32'h0F0F_0F0F);
        repeat (3) good_word();
        check_eq("reseed_early", 32'(locked), 32'd0);
        good_word();
        check_eq("reseed_lock", 32'(locked), 32'd1);

        step(1'b0, 32'h0, 1'b1);
        repeat (7) begin
            bad_word(1'b0);
            bad_word(1'b0);
            good_word();
        end
        check_eq("sat_pre", 32'(err_count), 32'd14);
        check_eq("sat_pre_locked", 32'(locked), 32'd1);
        bad_word(1'b0);
        check_eq("sat_a", 32'(err_count), 32'd15);
        bad_word(1'b0);
        check_eq("sat_b", 32'(err_count), 32'd15);
        bad_word(1'b0);
        check_eq("sat_c", 32'(err_count), 32'd15);
        check_eq("sat_locked", 32'(locked), 32'd0);

        acquire(32'h0000_0001);
        check_eq("sat_hold", 32'(err_count), 32'd15);
        bad_word(1'b1);
        check_eq("clr_same_cnt", 32'(err_count), 32'd1);
        check_eq("clr_same_pulse", 32'(err_pulse), 32'd1);
        step(1'b1, s, 1'b1);
        s = gen_next(s);
        check_eq("clr_match_cnt", 32'(err_count), 32'd0);
        check_eq("clr_keeps_lock", 32'(locked), 32'd1);

        repeat (2) step(1'b0, 32'h5555_AAAA, 1'b0);
        bad_word(1'b0);
        check_eq("pre_arst_cnt", 32'(err_count), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("arst_locked", 32'(locked), 32'd0);
        check_eq("arst_errcnt", 32'(err_count), 32'd0);
        check_eq("arst_pulse", 32'(err_pulse), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        acquire(32'h1234_5678);
        check_eq("relock_errcnt", 32'(err_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
